ysyx_24100029_gshare_bpu: RTL

// Parametrised gshare branch predictor for the IFU next-PC path. It replaces the per-PC-hash BHR/PHT scheme

---
 rtl/ysyx_24100029_gshare_bpu_pkg.sv | 25 ++
 rtl/ysyx_24100029_gshare_bpu_if.sv | 32 +++
 rtl/ysyx_24100029_ras.sv | 56 +++++
 rtl/ysyx_24100029_gshare_bpu.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ysyx_24100029_gshare_bpu_pkg.sv
// Shared types for the gshare branch predictor: branch kind encoding and BTB entry layout.
package ysyx_24100029_bpu_pkg;

  typedef enum logic [1:0] {
    COND = 2'b00,
    CALL = 2'b01,
    RET  = 2'b10,
    JUMP = 2'b11
  } br_type_e;

  // Tag storage is sized for the smallest legal BTB; unused upper bits stay zero and are trimmed.
  localparam int unsigned TAG_STORE_W = 30;

  typedef struct packed {
    logic                   valid;
    logic [TAG_STORE_W-1:0] tag;
    logic [31:0]            target;
    br_type_e               br_type;
  } btb_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_24100029_gshare_bpu_if.sv
// Fetch-side lookup and commit-side training/recovery signals of the branch predictor.
interface ysyx_24100029_gshare_bpu_if #(
  parameter int GHR_WIDTH = 6
);

  logic                 pc_update;
  logic [31:0]          pc;
  logic [31:0]          npc;
  logic                 pred_res;
  logic [GHR_WIDTH-1:0] pred_ghr;

  logic                 br_valid;
  logic                 br_is_taken;
  logic [31:0]          br_pc;
  logic [1:0]           br_pc_type;
  logic [31:0]          br_npc;
  logic [GHR_WIDTH-1:0] br_ghr;
  logic                 br_mispred;

  modport master (
    output pc_update, pc,
    output br_valid, br_is_taken, br_pc, br_pc_type, br_npc, br_ghr, br_mispred,
    input  npc, pred_res, pred_ghr
  );

  modport slave (
    input  pc_update, pc,
    input  br_valid, br_is_taken, br_pc, br_pc_type, br_npc, br_ghr, br_mispred,
    output npc, pred_res, pred_ghr
  );

endinterface

// File: rtl/ysyx_24100029_ras.sv
// Circular return address stack; a push onto a full stack overwrites the oldest entry.
module ysyx_24100029_ras #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      push_addr,
  output logic [31:0]      top,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    sp_d    = sp_q;
    count_d = count_q;
    if (push) begin
      mem_d[sp_q] = push_addr;
      sp_d        = sp_q + PTR_W'(1);
      if (count_q != CNT_W'(DEPTH)) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop && (count_q != '0)) begin
      sp_d    = sp_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
    end
  end

  // Stack contents carry no reset; count guards every read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign top   = mem_q[sp_q - PTR_W'(1)];
  assign count = count_q;

endmodule

// File: rtl/ysyx_24100029_gshare_bpu.sv
// Gshare predictor with direct-mapped BTB, return stack and speculative GHR with commit-time recovery.
module ysyx_24100029_gshare_bpu
  import ysyx_24100029_bpu_pkg::*;
#(
  parameter int GHR_WIDTH       = 6,
  parameter int PHT_INDEX_WIDTH = 8,
  parameter int CNT_WIDTH       = 2,
  parameter int BTB_INDEX_WIDTH = 4,
  parameter int RAS_DEPTH       = 8
) (
  input logic                       clock,
  input logic                       reset,
  ysyx_24100029_gshare_bpu_if.slave bpu
);

  localparam int PHT_ENTRIES = 1 << PHT_INDEX_WIDTH;
  localparam int BTB_ENTRIES = 1 << BTB_INDEX_WIDTH;
  localparam int RAS_CNT_W   = $clog2(RAS_DEPTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

  logic [CNT_WIDTH-1:0] pht_q [PHT_ENTRIES];
  logic [CNT_WIDTH-1:0] pht_d [PHT_ENTRIES];
  btb_entry_t           btb_q [BTB_ENTRIES];
  btb_entry_t           btb_d [BTB_ENTRIES];
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;

  logic [PHT_INDEX_WIDTH-1:0] lk_pidx;
  logic [BTB_INDEX_WIDTH-1:0] lk_bidx;
  btb_entry_t                 lk_entry;
  logic                       lk_hit;
  logic                       lk_cnt_taken;
  logic                       lk_taken;
  logic [31:0]                lk_target;
  logic [31:0]                lk_npc;

  logic                       recover;
  logic [PHT_INDEX_WIDTH-1:0] cm_pidx;
  logic [BTB_INDEX_WIDTH-1:0] cm_bidx;
  logic [CNT_WIDTH-1:0]       cm_cnt;
  br_type_e                   cm_type;

  logic                 ras_push;
  logic                 ras_pop;
  logic [31:0]          ras_top;
  logic [RAS_CNT_W-1:0] ras_count;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bpu.pc[1:0], bpu.br_pc[1:0]};

  // Zero-latency lookup: every read uses pre-edge state, so same-cycle commits are not bypassed.
  always_comb begin
    lk_pidx      = bpu.pc[2 +: PHT_INDEX_WIDTH] ^ PHT_INDEX_WIDTH'(ghr_q);
    lk_bidx      = bpu.pc[2 +: BTB_INDEX_WIDTH];
    lk_entry     = btb_q[lk_bidx];
    lk_hit       = lk_entry.valid &&
                   (lk_entry.tag == TAG_STORE_W'(bpu.pc[31:2+BTB_INDEX_WIDTH]));
    lk_cnt_taken = pht_q[lk_pidx][CNT_WIDTH-1];
    lk_taken     = lk_hit && ((lk_entry.br_type != COND) || lk_cnt_taken);
    if ((lk_entry.br_type == RET) && (ras_count != '0)) begin
      lk_target = ras_top;
    end else begin
      lk_target = lk_entry.target;
    end
    lk_npc = lk_taken ? lk_target : pc_plus4(bpu.pc);
  end

  assign bpu.npc      = lk_npc;
  assign bpu.pred_res = lk_taken;
  assign bpu.pred_ghr = ghr_q;

  always_comb begin
    ghr_d    = ghr_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    recover  = bpu.br_valid && bpu.br_mispred;
    cm_type  = br_type_e'(bpu.br_pc_type);

    if (bpu.pc_update && !recover) begin
      if (lk_hit && (lk_entry.br_type == COND)) begin
        ghr_d = (ghr_q << 1) | GHR_WIDTH'(lk_cnt_taken);
      end
      ras_push = lk_taken && (lk_entry.br_type == CALL);
      ras_pop  = lk_taken && (lk_entry.br_type == RET) && (ras_count != '0);
    end

    // A mispredict restarts history from the checkpoint the branch carried down the pipe.
    if (recover) begin
      if (cm_type == COND) begin
        ghr_d = (bpu.br_ghr << 1) | GHR_WIDTH'(bpu.br_is_taken);
      end else begin
        ghr_d = bpu.br_ghr;
      end
    end
  end

  always_comb begin
    pht_d   = pht_q;
    btb_d   = btb_q;
    cm_pidx = bpu.br_pc[2 +: PHT_INDEX_WIDTH] ^ PHT_INDEX_WIDTH'(bpu.br_ghr);
    cm_bidx = bpu.br_pc[2 +: BTB_INDEX_WIDTH];
    cm_cnt  = pht_q[cm_pidx];

    if (bpu.br_valid) begin
      if (cm_type == COND) begin
        if (bpu.br_is_taken && (cm_cnt != CNT_MAX)) begin
          pht_d[cm_pidx] = cm_cnt + CNT_WIDTH'(1);
        end else if (!bpu.br_is_taken && (cm_cnt != '0)) begin
          pht_d[cm_pidx] = cm_cnt - CNT_WIDTH'(1);
        end
      end
      // Not-taken commits leave the BTB alone so a previously learnt target survives.
      if (bpu.br_is_taken) begin
        btb_d[cm_bidx].valid   = 1'b1;
        btb_d[cm_bidx].tag     = TAG_STORE_W'(bpu.br_pc[31:2+BTB_INDEX_WIDTH]);
        btb_d[cm_bidx].target  = bpu.br_npc;
        btb_d[cm_bidx].br_type = cm_type;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= CNT_INIT;
      end
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '0;
      end
      ghr_q <= '0;
    end else begin
      pht_q <= pht_d;
      btb_q <= btb_d;
      ghr_q <= ghr_d;
    end
  end

  ysyx_24100029_ras #(
    .DEPTH (RAS_DEPTH),
    .CNT_W (RAS_CNT_W)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_addr (pc_plus4(bpu.pc)),
    .top       (ras_top),
    .count     (ras_count)
  );

endmodule
